// File: rtl/mul_acc_if.sv
// rtl/mul_acc_if.sv - product-in / sum-out handshake bundle for mul_acc
interface mul_acc_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 8
) ();
    logic                 start;
    logic [CNT_WIDTH-1:0] len;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_ovf;

    // Producer/consumer side: issues transactions, feeds products, takes sums
    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    // Accumulator side
    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mul_acc.sv
// rtl/mul_acc.sv - saturating multiply-accumulate stage with length-programmed transactions
module mul_acc #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 8
) (
    input  logic      clock,
    input  logic      reset_n,
    mul_acc_if.slave  bus,
    output logic      busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_q;
    logic [CNT_WIDTH-1:0] rem_q;

    logic [ACC_WIDTH:0]   sum_d;
    logic [ACC_WIDTH-1:0] acc_sat_d;
    logic                 carry_d;
    logic                 start_ok_d;

    // One extra bit of headroom exposes the carry used for saturation
    always_comb begin
        sum_d      = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, bus.in_data};
        carry_d    = sum_d[ACC_WIDTH];
        acc_sat_d  = carry_d ? {ACC_WIDTH{1'b1}} : sum_d[ACC_WIDTH-1:0];
        // A start is honoured in IDLE, or in DONE on the cycle the result is taken
        start_ok_d = bus.start &&
                     ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    end

    // Transaction FSM: owns state, running sum, sticky overflow and beat count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else if (start_ok_d) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= bus.len;
            state_q <= (bus.len != '0) ? ACCUM : DONE;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_q <= acc_sat_d;
                        ovf_q <= ovf_q | carry_d;
                        rem_q <= rem_q - CNT_WIDTH'(1);
                        if (rem_q == CNT_WIDTH'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded purely from registered state
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign busy          = (state_q != IDLE);
endmodule
